m68k_bus_target: RTL and testbench

- 68000 bus responder (target side of the CPU bus cycle the bridge initiates).
- Oversamples AS/UDS/LDS/RW on a fast clock, decodes an address window, and forwards the access to a req/ack backend (register file or SRAM).
- Terminates the cycle with DTACK, or BERR on timeout; optional 6800-style VPA termination.
- Used for the on-board expansion/scratch window and as the bus model for bench checks of the initiator.

---
 rtl/m68k_bus_target.sv | 232 +++++++++++++++++++++++
 tb/tb_m68k_bus_target.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_target.sv
// 68000 bus responder: oversamples the bus strobes on PI_CLK, decodes an address window and
// forwards accesses to a req/ack backend. Define M68K_VPA_EN to enable 6800-style VPA termination.
module m68k_bus_target #(
  parameter logic [23:0] BASE_ADDR   = 24'h200000,
  parameter logic [23:0] ADDR_MASK   = 24'hE00000,
  parameter int          WAIT_CYCLES = 4,
  parameter int          TIMEOUT     = 1023,
  parameter logic [23:0] VPA_BASE    = 24'hBFE000,
  parameter logic [23:0] VPA_MASK    = 24'hFFF000
) (
  input  logic        PI_CLK,
  input  logic        RESET,
  input  logic [22:0] M68K_A,
  input  logic [2:0]  M68K_FC,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  input  logic [15:0] M68K_D_IN,
  output logic [15:0] M68K_D_OUT,
  output logic        M68K_D_OE,
  output logic        M68K_DTACK_n,
  output logic        M68K_BERR_n,
  output logic        M68K_VPA_n,
  input  logic        M68K_VMA_n,
  output logic        BE_REQ,
  output logic        BE_RW,
  output logic [22:0] BE_ADDR,
  output logic [1:0]  BE_BE,
  output logic [15:0] BE_WDATA,
  input  logic [15:0] BE_RDATA,
  input  logic        BE_ACK
);

  localparam int WCNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_V    = WCNT_W'(WAIT_CYCLES);
  localparam logic [TCNT_W-1:0] TIMEOUT_V = TCNT_W'(TIMEOUT);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_STROBE   = 3'd1;
  localparam logic [2:0] S_DECODE   = 3'd2;
  localparam logic [2:0] S_IGNORE   = 3'd3;
  localparam logic [2:0] S_ACCESS   = 3'd4;
  localparam logic [2:0] S_RESPOND  = 3'd5;
  localparam logic [2:0] S_ERROR    = 3'd6;
`ifdef M68K_VPA_EN
  localparam logic [2:0] S_VPA_WAIT = 3'd7;
`endif

  logic [4:0]        sync1_q, sync1_d, sync2_q, sync2_d;
  logic              as_s, uds_s, lds_s, rw_s, vma_s;
  logic [2:0]        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              ack_seen_q, ack_seen_d;
  logic              be_req_q, be_req_d, be_rw_q, be_rw_d;
  logic [22:0]       be_addr_q, be_addr_d;
  logic [1:0]        be_be_q, be_be_d;
  logic [15:0]       be_wdata_q, be_wdata_d, d_out_q, d_out_d;
  logic              d_oe_q, d_oe_d, dtack_n_q, dtack_n_d, berr_n_q, berr_n_d, vpa_n_q, vpa_n_d;
  logic [23:0]       byte_addr;
  logic              win_hit, iack;

  assign {as_s, uds_s, lds_s, rw_s, vma_s} = sync2_q;
  assign byte_addr = {M68K_A, 1'b0};
  assign win_hit   = (byte_addr & ADDR_MASK) == BASE_ADDR;
  assign iack      = (M68K_FC == 3'b111);

`ifdef M68K_VPA_EN
  logic vpa_hit;
  assign vpa_hit = (byte_addr & VPA_MASK) == VPA_BASE;
`else
  logic unused_vpa;
  assign unused_vpa = vma_s ^ (|VPA_BASE) ^ (|VPA_MASK);
`endif

  // Two-flop synchronisers for the asynchronous bus strobes
  always_comb begin
    sync1_d = {M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW, M68K_VMA_n};
    sync2_d = sync1_q;
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    tcnt_d     = tcnt_q;
    ack_seen_d = ack_seen_q;
    be_req_d   = be_req_q;
    be_rw_d    = be_rw_q;
    be_addr_d  = be_addr_q;
    be_be_d    = be_be_q;
    be_wdata_d = be_wdata_q;
    d_out_d    = d_out_q;
    d_oe_d     = d_oe_q;
    dtack_n_d  = dtack_n_q;
    berr_n_d   = berr_n_q;
    vpa_n_d    = vpa_n_q;
    case (state_q)
      S_IDLE:   if (!as_s) state_d = S_STROBE;
      // Writes assert the data strobes a bus clock after AS
      S_STROBE: begin
        if (as_s) state_d = S_IDLE;
        else if (!uds_s || !lds_s) state_d = S_DECODE;
      end
      S_DECODE: begin
        be_addr_d  = M68K_A;
        be_rw_d    = rw_s;
        be_be_d    = {~uds_s, ~lds_s};
        be_wdata_d = M68K_D_IN;
        wcnt_d     = '0;
        tcnt_d     = '0;
        ack_seen_d = 1'b0;
        if (iack) state_d = S_IGNORE;
`ifdef M68K_VPA_EN
        else if (vpa_hit) begin
          state_d = S_VPA_WAIT;
          vpa_n_d = 1'b0;
        end
`endif
        else if (win_hit) begin
          state_d  = S_ACCESS;
          be_req_d = 1'b1;
        end else state_d = S_IGNORE;
      end
      S_IGNORE: if (as_s) state_d = S_IDLE;
`ifdef M68K_VPA_EN
      S_VPA_WAIT: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (as_s) begin
          state_d = S_IDLE;
          vpa_n_d = 1'b1;
        end else if (!vma_s) begin
          state_d  = S_ACCESS;
          be_req_d = 1'b1;
          wcnt_d   = '0;
          tcnt_d   = '0;
        end else if (tcnt_q == TIMEOUT_V) begin
          state_d  = S_ERROR;
          berr_n_d = 1'b0;
          d_oe_d   = 1'b0;
        end
      end
`endif
      // Ack is checked ahead of the timeout so a same-cycle ack completes the cycle
      S_ACCESS: begin
        if (wcnt_q != WAIT_V) wcnt_d = wcnt_q + WCNT_W'(1);
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (as_s) begin
          state_d    = S_IDLE;
          be_req_d   = 1'b0;
          ack_seen_d = 1'b0;
          vpa_n_d    = 1'b1;
        end else if (ack_seen_q && wcnt_q == WAIT_V) begin
          state_d   = S_RESPOND;
          dtack_n_d = ~vpa_n_q;
          d_oe_d    = be_rw_q;
        end else if (be_req_q && BE_ACK) begin
          be_req_d   = 1'b0;
          ack_seen_d = 1'b1;
          if (be_rw_q) d_out_d = BE_RDATA;
        end else if (!ack_seen_q && tcnt_q == TIMEOUT_V) begin
          state_d  = S_ERROR;
          be_req_d = 1'b0;
          berr_n_d = 1'b0;
          d_oe_d   = 1'b0;
        end
      end
      S_RESPOND, S_ERROR: begin
        if (as_s) begin
          state_d    = S_IDLE;
          dtack_n_d  = 1'b1;
          berr_n_d   = 1'b1;
          vpa_n_d    = 1'b1;
          d_oe_d     = 1'b0;
          ack_seen_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PI_CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q    <= 5'b11111;
      sync2_q    <= 5'b11111;
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      tcnt_q     <= '0;
      ack_seen_q <= 1'b0;
      be_req_q   <= 1'b0;
      be_rw_q    <= 1'b1;
      be_addr_q  <= '0;
      be_be_q    <= '0;
      be_wdata_q <= '0;
      d_out_q    <= '0;
      d_oe_q     <= 1'b0;
      dtack_n_q  <= 1'b1;
      berr_n_q   <= 1'b1;
      vpa_n_q    <= 1'b1;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      tcnt_q     <= tcnt_d;
      ack_seen_q <= ack_seen_d;
      be_req_q   <= be_req_d;
      be_rw_q    <= be_rw_d;
      be_addr_q  <= be_addr_d;
      be_be_q    <= be_be_d;
      be_wdata_q <= be_wdata_d;
      d_out_q    <= d_out_d;
      d_oe_q     <= d_oe_d;
      dtack_n_q  <= dtack_n_d;
      berr_n_q   <= berr_n_d;
      vpa_n_q    <= vpa_n_d;
    end
  end

  assign M68K_D_OUT   = d_out_q;
  assign M68K_D_OE    = d_oe_q;
  assign M68K_DTACK_n = dtack_n_q;
  assign M68K_BERR_n  = berr_n_q;
  assign M68K_VPA_n   = vpa_n_q;
  assign BE_REQ       = be_req_q;
  assign BE_RW        = be_rw_q;
  assign BE_ADDR      = be_addr_q;
  assign BE_BE        = be_be_q;
  assign BE_WDATA     = be_wdata_q;

endmodule

// File: tb/tb_m68k_bus_target.sv
// Self-checking bench for m68k_bus_target: table of bus cycles with a backend-request scoreboard,
// plus hand sequences for timeout, ack-at-timeout, reset mid-access and (with M68K_VPA_EN) VPA.
module tb_m68k_bus_target;
  logic        clk = 1'b0;
  logic        rst;
  logic [22:0] a;
  logic [2:0]  fc;
  logic        as_n, uds_n, lds_n, rw, vma_n;
  logic [15:0] d_in, d_out, be_rdata;
  logic        d_oe, dtack_n, berr_n, vpa_n;
  logic        be_req, be_rw, be_ack;
  logic [22:0] be_addr;
  logic [1:0]  be_be;
  logic [15:0] be_wdata;

  typedef struct {
    logic [23:0] addr;
    logic [2:0]  fc;
    logic        rw;
    logic        uds;
    logic        lds;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          ack_dly;
    logic        exp_req;
    logic [1:0]  exp_be;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [22:0] addr;
    logic        rw;
    logic [1:0]  be;
    logic [15:0] wdata;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[7];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  m68k_bus_target dut (
    .PI_CLK(clk), .RESET(rst), .M68K_A(a), .M68K_FC(fc), .M68K_AS_n(as_n),
    .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw), .M68K_D_IN(d_in),
    .M68K_D_OUT(d_out), .M68K_D_OE(d_oe), .M68K_DTACK_n(dtack_n), .M68K_BERR_n(berr_n),
    .M68K_VPA_n(vpa_n), .M68K_VMA_n(vma_n), .BE_REQ(be_req), .BE_RW(be_rw),
    .BE_ADDR(be_addr), .BE_BE(be_be), .BE_WDATA(be_wdata), .BE_RDATA(be_rdata), .BE_ACK(be_ack)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic start_cycle(input vec_t v);
    exp_t e;
    if (v.exp_req) begin
      e.addr  = v.addr[23:1];
      e.rw    = v.rw;
      e.be    = v.exp_be;
      e.wdata = v.wdata;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    a = v.addr[23:1]; fc = v.fc; rw = v.rw; d_in = v.wdata; as_n = 1'b0;
    if (!v.rw) begin
      repeat (16) @(posedge clk);
      #1;
    end
    uds_n = ~v.uds; lds_n = ~v.lds;
  endtask

  task automatic wait_req(input int limit, output bit seen);
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (be_req) seen = 1'b1;
    end
    if (seen) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_req: BE_REQ rose with addr %0h, none expected", be_addr);
      end else begin
        e = sb_q.pop_front();
        chk("be_addr", 32'(be_addr), 32'(e.addr));
        chk("be_rw", 32'(be_rw), 32'(e.rw));
        chk("be_be", 32'(be_be), 32'(e.be));
        chk("be_wdata", 32'(be_wdata), 32'(e.wdata));
      end
    end
  endtask

  task automatic release_bus(input logic exp_dt, input logic exp_be);
    @(posedge clk); #1;
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_dtack", 32'(dtack_n), 32'(exp_dt));
    chk("hold_berr", 32'(berr_n), 32'(exp_be));
    @(negedge clk);
    chk("rel_dtack", 32'(dtack_n), 1);
    chk("rel_berr", 32'(berr_n), 1);
    chk("rel_doe", 32'(d_oe), 0);
    chk("rel_vpa", 32'(vpa_n), 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    bit seen;
    int k;
    bit done;
    start_cycle(v);
    wait_req(60, seen);
    chk("req_seen", 32'(seen), 32'(v.exp_req));
    if (seen) begin
      k = 0; done = 1'b0;
      be_rdata = v.rdata;
      be_ack = (v.ack_dly == 0);
      while (!done && k < 40) begin
        @(negedge clk);
        k++;
        be_ack = (k == v.ack_dly);
        if (!dtack_n || !berr_n) done = 1'b1;
      end
      be_ack = 1'b0;
      chk("dtack_lat", 32'(k), 32'(v.exp_lat));
      chk("resp_dtack", 32'(dtack_n), 0);
      chk("resp_berr", 32'(berr_n), 1);
      chk("resp_doe", 32'(d_oe), 32'(v.rw));
      if (v.rw) chk("resp_dout", 32'(d_out), 32'(v.rdata));
      release_bus(1'b0, 1'b1);
    end else begin
      chk("ign_dtack", 32'(dtack_n), 1);
      chk("ign_berr", 32'(berr_n), 1);
      chk("ign_req", 32'(be_req), 0);
      release_bus(1'b1, 1'b1);
    end
    chk("vpa_idle", 32'(vpa_n), 1);
  endtask

  task automatic timeout_run(input bit ack_at_limit);
    vec_t tv;
    bit   seen;
    tv = '{24'h200020, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h5A5A, 0, 1'b1, 2'b11, 0};
    start_cycle(tv);
    wait_req(60, seen);
    chk("to_req", 32'(seen), 1);
    be_rdata = 16'h5A5A;
    repeat (1023) @(negedge clk);
    chk("to_berr_pre", 32'(berr_n), 1);
    chk("to_req_pre", 32'(be_req), 1);
    be_ack = ack_at_limit;
    @(negedge clk);
    be_ack = 1'b0;
    chk("to_req_drop", 32'(be_req), 0);
    chk("to_berr", 32'(berr_n), ack_at_limit ? 1 : 0);
    @(negedge clk);
    chk("to_dtack", 32'(dtack_n), ack_at_limit ? 0 : 1);
    if (ack_at_limit) chk("to_dout", 32'(d_out), 32'h5A5A);
    release_bus(ack_at_limit ? 1'b0 : 1'b1, ack_at_limit ? 1'b1 : 1'b0);
  endtask

  initial begin
    bit   seen;
    vec_t rv;
    vecs[0] = '{24'h200010, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0000, 16'hBEEF, 0, 1'b1, 2'b11, 5};
    vecs[1] = '{24'h200003, 3'd5, 1'b0, 1'b0, 1'b1, 16'h0055, 16'h0000, 0, 1'b1, 2'b01, 5};
    vecs[2] = '{24'h3FFFFE, 3'd6, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234, 5, 1'b1, 2'b10, 7};
    vecs[3] = '{24'h2ABCD0, 3'd1, 1'b0, 1'b1, 1'b1, 16'hA5C3, 16'h0000, 4, 1'b1, 2'b11, 6};
    vecs[4] = '{24'h400000, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 0, 1'b0, 2'b00, 0};
    vecs[5] = '{24'h200010, 3'd7, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 0, 1'b0, 2'b00, 0};
    vecs[6] = '{24'h1FFFFE, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 0, 1'b0, 2'b00, 0};

    rst = 1'b1; a = '0; fc = 3'd0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    vma_n = 1'b1; d_in = '0; be_rdata = '0; be_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dtack", 32'(dtack_n), 1);
    chk("rst_berr", 32'(berr_n), 1);
    chk("rst_vpa", 32'(vpa_n), 1);
    chk("rst_doe", 32'(d_oe), 0);
    chk("rst_dout", 32'(d_out), 0);
    chk("rst_req", 32'(be_req), 0);
    chk("rst_berw", 32'(be_rw), 1);
    chk("rst_addr", 32'(be_addr), 0);
    chk("rst_be", 32'(be_be), 0);
    chk("rst_wdata", 32'(be_wdata), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    // A stray ack while idle must not start or terminate anything
    @(negedge clk);
    be_rdata = 16'hDEAD; be_ack = 1'b1;
    @(negedge clk);
    be_ack = 1'b0;
    repeat (5) @(negedge clk);
    chk("stray_ack_dtack", 32'(dtack_n), 1);
    chk("stray_ack_req", 32'(be_req), 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    timeout_run(1'b0);
    timeout_run(1'b1);

    // Reset pulse while a request is outstanding
    rv = vecs[0];
    rv.rdata = 16'h7E57;
    start_cycle(rv);
    wait_req(60, seen);
    chk("mid_req", 32'(seen), 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(be_req), 0);
    chk("mid_rst_dtack", 32'(dtack_n), 1);
    chk("mid_rst_berr", 32'(berr_n), 1);
    chk("mid_rst_doe", 32'(d_oe), 0);
    chk("mid_rst_dout", 32'(d_out), 0);
    chk("mid_rst_addr", 32'(be_addr), 0);
    chk("mid_rst_berw", 32'(be_rw), 1);
    chk("mid_rst_be", 32'(be_be), 0);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    run_vec(rv);

`ifdef M68K_VPA_EN
    rv = '{24'hBFE001, 3'd5, 1'b1, 1'b0, 1'b1, 16'h0000, 16'hC0DE, 0, 1'b1, 2'b01, 0};
    start_cycle(rv);
    repeat (10) @(negedge clk);
    chk("vpa_low", 32'(vpa_n), 0);
    chk("vpa_noreq", 32'(be_req), 0);
    vma_n = 1'b0;
    wait_req(20, seen);
    chk("vpa_req", 32'(seen), 1);
    be_rdata = 16'hC0DE; be_ack = 1'b1;
    @(negedge clk);
    be_ack = 1'b0;
    repeat (8) @(negedge clk);
    chk("vpa_doe", 32'(d_oe), 1);
    chk("vpa_dtack", 32'(dtack_n), 1);
    chk("vpa_dout", 32'(d_out), 32'hC0DE);
    chk("vpa_hold", 32'(vpa_n), 0);
    vma_n = 1'b1;
    release_bus(1'b1, 1'b1);
`endif

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
